sobel_frame_sequencer: RTL and testbench



---
 rtl/sobel_pkg.sv | 11 +
 rtl/sobel_kernel.sv | 19 +
 rtl/sobel_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types, request codes and saturation helper for the Sobel frame sequencer
package sobel_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, DONE} state_t;
  typedef logic [8:0][7:0] window_t;
  localparam logic [1:0] INSTR_IDLE  = 2'b00;
  localparam logic [1:0] INSTR_READ  = 2'b01;
  localparam logic [1:0] INSTR_WRITE = 2'b10;
  function automatic logic [7:0] sat8(input logic [11:0] m);
    return (m > 12'd255) ? 8'hFF : m[7:0];
  endfunction
endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: combinational 3x3 Sobel magnitude |Gx|+|Gy|, saturated to 8 bits
module sobel_kernel
  import sobel_pkg::*;
(
  input  window_t    win,
  output logic [7:0] mag
);
  logic [10:0] gx, gy, ax, ay;
  // Gx/Gy are formed as 11-bit two's complement; |G| never exceeds 1020
  always_comb begin
    gx = ({3'b0, win[2]} + {2'b0, win[5], 1'b0} + {3'b0, win[8]})
       - ({3'b0, win[0]} + {2'b0, win[3], 1'b0} + {3'b0, win[6]});
    gy = ({3'b0, win[6]} + {2'b0, win[7], 1'b0} + {3'b0, win[8]})
       - ({3'b0, win[0]} + {2'b0, win[1], 1'b0} + {3'b0, win[2]});
    ax = gx[10] ? -gx : gx;
    ay = gy[10] ? -gy : gy;
    mag = sat8({1'b0, ax} + {1'b0, ay});
  end
endmodule

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: walks a frame, fetches 3x3 windows, writes saturated Sobel magnitudes
// Define SOBEL_WINDOW_REUSE_EN to shift the window within a row and fetch only the new right column.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       read_data_done,
  input  logic [7:0] data_r_o,
  input  logic       write_done,
  output logic       start_read,
  output logic [7:0] addr_r_mc,
  output logic       start_write,
  output logic [7:0] addr_w_mc,
  output logic [7:0] data_w,
  output logic       active,
  output logic       frame_done
);
`ifdef SOBEL_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam int SRC_END = SRC_BASE + IMG_W * IMG_H;
  localparam int DST_END = DST_BASE + (IMG_W - 2) * (IMG_H - 2);
  if (IMG_W < 3 || IMG_H < 3 || SRC_END > 256 || DST_END > 256 ||
      !(SRC_END <= DST_BASE || DST_END <= SRC_BASE)) begin : g_bad_cfg
    $error("sobel_frame_sequencer: invalid image geometry or overlapping buffers");
  end
  state_t state, state_n;
  window_t win;
  logic [7:0] r, c, res, mag8, src_addr, dst_addr;
  logic [1:0] kr, kc, instr;
  logic [3:0] tap;
  logic narrow, last_tap, last_col, last_row;
  sobel_kernel u_kernel (.win(win), .mag(mag8));
  assign tap      = {2'b0, kr} * 4'd3 + {2'b0, kc};
  assign last_tap = kr == 2'd2 && kc == 2'd2;
  assign last_col = c == 8'(IMG_W - 2);
  assign last_row = r == 8'(IMG_H - 2);
  assign src_addr = 8'(SRC_BASE + (int'(r) + int'(kr) - 1) * IMG_W + int'(c) + int'(kc) - 1);
  assign dst_addr = 8'(DST_BASE + (int'(r) - 1) * (IMG_W - 2) + int'(c) - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = (read_data_done && last_tap) ? CALC : FETCH;
      CALC:    state_n = WRITE;
      WRITE:   state_n = write_done ? ((last_col && last_row) ? DONE : FETCH) : WRITE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    instr       = (state == FETCH) ? INSTR_READ : (state == WRITE) ? INSTR_WRITE : INSTR_IDLE;
    start_read  = instr == INSTR_READ;
    start_write = instr == INSTR_WRITE;
    addr_r_mc   = start_read ? src_addr : 8'h00;
    addr_w_mc   = start_write ? dst_addr : 8'h00;
    data_w      = start_write ? res : 8'h00;
    active      = state != IDLE;
    frame_done  = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      win    <= '0;
      r      <= '0;
      c      <= '0;
      kr     <= '0;
      kc     <= '0;
      narrow <= 1'b0;
      res    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          r      <= 8'd1;
          c      <= 8'd1;
          kr     <= '0;
          kc     <= '0;
          narrow <= 1'b0;
        end
        FETCH: if (read_data_done) begin
          win[tap] <= data_r_o;
          if (narrow || kc == 2'd2) begin
            kr <= kr + 2'd1;
            kc <= narrow ? 2'd2 : 2'd0;
          end else kc <= kc + 2'd1;
        end
        CALC: res <= mag8;
        WRITE: if (write_done) begin
          kr <= '0;
          if (last_col) begin
            c      <= 8'd1;
            r      <= r + 8'd1;
            kc     <= '0;
            narrow <= 1'b0;
          end else begin
            c      <= c + 8'd1;
            kc     <= REUSE ? 2'd2 : 2'd0;
            narrow <= REUSE;
            // slide the window left so only the right column needs refetching
            if (REUSE) begin
              win[0] <= win[1];
              win[1] <= win[2];
              win[3] <= win[4];
              win[4] <= win[5];
              win[6] <= win[7];
              win[7] <= win[8];
            end
          end
        end
        DONE: begin
          r <= '0;
          c <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb_sobel_frame_sequencer: table-driven frames against a memory/arbiter model and arithmetic Sobel reference
module tb_sobel_frame_sequencer;
  localparam int W = 8, H = 8, SRC = 0, DST = 64;
  localparam int NOUT = (W - 2) * (H - 2);
`ifdef SOBEL_WINDOW_REUSE_EN
  localparam int EXP_CYC = (H - 2) * (11 + (W - 3) * 5);
`else
  localparam int EXP_CYC = NOUT * 11;
`endif
  logic clk = 0, rst = 1, start = 0, busy = 0, busy_en = 0;
  logic read_data_done, write_done, start_read, start_write, active, frame_done;
  logic [7:0] data_r_o, addr_r_mc, addr_w_mc, data_w;
  logic [7:0] mem [256];
  int img [W*H];
  int rnd [W*H];
  int n_checks = 0, n_fail = 0, writes = 0, dones = 0;
  logic rd_pend = 0, wr_pend = 0;
  logic [7:0] rd_addr, wr_addr, wr_data;

  sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clk(clk), .rst(rst), .start(start), .read_data_done(read_data_done), .data_r_o(data_r_o),
    .write_done(write_done), .start_read(start_read), .addr_r_mc(addr_r_mc),
    .start_write(start_write), .addr_w_mc(addr_w_mc), .data_w(data_w),
    .active(active), .frame_done(frame_done));

  always #5 clk = ~clk;
  assign read_data_done = start_read & ~busy;
  assign write_done     = start_write & ~busy;
  assign data_r_o       = read_data_done ? mem[addr_r_mc] : 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (start_write && write_done) begin
      mem[addr_w_mc] = data_w;
      writes++;
    end
    if (frame_done) dones++;
    #2 busy = busy_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 0;
      wr_pend = 0;
    end else begin
      if (start_read || start_write) check("strobe_overlap", int'(start_read & start_write), 0);
      if (rd_pend) check("read_hold", {start_read, addr_r_mc}, {1'b1, rd_addr});
      if (wr_pend) check("write_hold", {start_write, addr_w_mc, data_w}, {1'b1, wr_addr, wr_data});
      rd_pend = start_read && !read_data_done;
      wr_pend = start_write && !write_done;
      rd_addr = addr_r_mc;
      wr_addr = addr_w_mc;
      wr_data = data_w;
    end
  end

  function automatic int px(int r, int c);
    return img[r*W + c];
  endfunction

  function automatic int ref_px(int r, int c);
    int gx, gy;
    gx = (px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)) - (px(r-1, c-1) + 2*px(r, c-1) + px(r+1, c-1));
    gy = (px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1)) - (px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1));
    gx = gx < 0 ? -gx : gx;
    gy = gy < 0 ? -gy : gy;
    return (gx + gy > 255) ? 255 : gx + gy;
  endfunction

  task automatic load(input int pat);
    for (int i = 0; i < W*H; i++) begin
      case (pat)
        0: img[i] = 8'h80;
        1: img[i] = (i % W >= 4) ? 255 : 0;
        2: img[i] = 10 * (i % W);
        default: img[i] = rnd[i];
      endcase
      mem[SRC + i] = 8'(img[i]);
    end
    for (int i = 0; i < NOUT; i++) mem[DST + i] = 8'hEE;
  endtask

  task automatic run_frame(input int pat, input bit b, input bit spam, output int cycles);
    load(pat);
    writes = 0;
    dones = 0;
    busy_en = b;
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    cycles = 0;
    while (cycles < 5000 && !frame_done) begin
      @(posedge clk);
      #1 cycles++;
      if (spam) start = (writes < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 0;
    busy_en = 0;
    check("frame_done_seen", int'(frame_done), 1);
    repeat (10) @(posedge clk);
    #1;
    check("write_count", writes, NOUT);
    check("frame_done_count", dones, 1);
    check("active_after", int'(active), 0);
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        check($sformatf("pix_r%0d_c%0d", r, c), int'(mem[DST + (r-1)*(W-2) + c-1]), ref_px(r, c));
  endtask

  typedef struct { int pat; bit busy; bit spam; int spot_idx; int spot_val; } vec_t;

  initial begin
    vec_t vecs[6];
    int cyc, guard;
    vecs = '{'{0, 0, 0, 5, 0}, '{1, 0, 0, 2, 255}, '{2, 0, 0, 7, 80},
             '{3, 0, 0, -1, 0}, '{3, 1, 0, -1, 0}, '{1, 1, 1, 3, 255}};
    for (int i = 0; i < W*H; i++) rnd[i] = int'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {start_read, addr_r_mc, start_write, addr_w_mc, data_w, active, frame_done}, 0);
    rst = 0;
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].pat, vecs[v].busy, vecs[v].spam, cyc);
      if (!vecs[v].busy && !vecs[v].spam) check("done_cycle", cyc, EXP_CYC);
      if (vecs[v].spot_idx >= 0) check("spot", int'(mem[DST + vecs[v].spot_idx]), vecs[v].spot_val);
    end
    load(3);
    writes = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    guard = 0;
    while (!(writes == 4 && start_read) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_5th_fetch", int'(writes == 4 && start_read), 1);
    @(negedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;
    check("mid_rst_outputs", {start_read, addr_r_mc, start_write, addr_w_mc, data_w, active, frame_done}, 0);
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", {start_read, start_write, active}, 0);
    check("partial_writes", writes, 4);
    run_frame(2, 0, 0, cyc);
    check("done_cycle_after_rst", cyc, EXP_CYC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
